// File: rtl/cp0_pkg.sv
// -----------------------------------------------------------------------------
// cp0_pkg
// Shared definitions for the Coprocessor-0 slice of the multi-cycle MIPS core:
// CP0 register numbers, ExcCode values, redirect FSM state encoding and the
// bit positions of the SR / Cause fields.
// -----------------------------------------------------------------------------
package cp0_pkg;

  // CP0 register numbers (mfc0/mtc0 rd field)
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_SR      = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [4:0] REG_PRID    = 5'd15;

  // ExcCode values written into Cause[6:2]
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR / Cause field positions
  localparam int SR_IE_BIT    = 0;
  localparam int SR_EXL_BIT   = 1;
  localparam int SR_IM_LSB    = 10;
  localparam int CAUSE_IP_LSB = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_TI_BIT = 30;

  // Redirect handshake FSM
  typedef enum logic [1:0] {
    S_RUN     = 2'd0,  // normal execution, watching for requests
    S_PEND    = 2'd1,  // redirect requested, waiting for controller ack
    S_HANDLER = 2'd2   // handler running, waiting for eret
  } cp0_state_e;

endpackage : cp0_pkg

// File: rtl/cp0_timer.sv
// -----------------------------------------------------------------------------
// cp0_timer
// Count / Compare timer for CP0. Count increments every cycle (wrapping at 32
// bits) unless loaded by mtc0. When Count equals a non-zero Compare the sticky
// timer interrupt TI is set; any mtc0 to Compare clears TI, and that clear
// takes priority over a match in the same cycle.
// Only instantiated when CP0_TIMER_EN is defined.
//
// Ports
//   clk           in   clock
//   reset         in   synchronous, active-high
//   we_count_i    in   mtc0 write to Count this cycle
//   we_compare_i  in   mtc0 write to Compare this cycle
//   din_i         in   mtc0 write data
//   count_o       out  current Count
//   compare_o     out  current Compare
//   ti_o          out  sticky timer interrupt
// -----------------------------------------------------------------------------
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_count_i,
  input  logic        we_compare_i,
  input  logic [31:0] din_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        ti_o
);

  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic        ti_q;

  // NOTE: clocked state uses non-blocking assignments only, so every register
  // sees the pre-edge value of every other register regardless of order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
    end else begin
      count_q <= we_count_i ? din_i : count_q + 32'd1;

      if (we_compare_i) begin
        compare_q <= din_i;
      end

      // Compare == 0 is the "timer off" value and never raises TI.
      if (we_compare_i) begin
        ti_q <= 1'b0;
      end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
        ti_q <= 1'b1;
      end
    end
  end

  assign count_o   = count_q;
  assign compare_o = compare_q;
  assign ti_o      = ti_q;

endmodule : cp0_timer

// File: rtl/cp0_unit.sv
// -----------------------------------------------------------------------------
// cp0_unit
// Coprocessor-0 for the multi-cycle MIPS core. Owns SR / Cause / EPC / PRId,
// turns synchronous exceptions and masked interrupts into a redirect request
// handshaken with the controller (exc_req / exc_ack), captures EPC on the ack,
// and serves mfc0 (dout), mtc0 (we/din) and eret.
//
// Optional feature: define CP0_TIMER_EN to add Count (9) / Compare (11) and a
// timer interrupt ORed into IP[15] (cp0_timer sub-module). Without it those
// registers read 0 and ignore writes.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous, active-high
//   pc   [31:0] in   PC at the current boundary, captured into EPC on ack
//   addr [4:0]  in   CP0 register number for mfc0/mtc0
//   din  [31:0] in   mtc0 write data
//   we          in   mtc0 write strobe
//   eret        in   eret strobe
//   exc_valid   in   synchronous exception this cycle
//   exc_code    in   ExcCode for exc_valid
//   hw_int      in   level-sensitive hardware interrupt lines
//   exc_ack     in   controller took the redirect
//   exc_req     out  redirect request (registered)
//   in_handler  out  SR.EXL
//   epc  [31:0] out  EPC to the next-PC logic
//   dout [31:0] out  mfc0 read data, combinational on addr
// -----------------------------------------------------------------------------
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID  = 32'h0042_0001,
  parameter int          INT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc,
  input  logic [4:0]       addr,
  input  logic [31:0]      din,
  input  logic             we,
  input  logic             eret,
  input  logic             exc_valid,
  input  logic [4:0]       exc_code,
  input  logic [INT_W-1:0] hw_int,
  input  logic             exc_ack,
  output logic             exc_req,
  output logic             in_handler,
  output logic [31:0]      epc,
  output logic [31:0]      dout
);

  // Architectural state
  cp0_state_e       state_q;
  logic             exc_req_q;
  logic [4:0]       pend_code_q;   // code latched when the request is raised
  logic [INT_W-1:0] im_q, im_d;
  logic             ie_q, ie_d;
  logic             exl_q, exl_d;
  logic [INT_W-1:0] ip_q;          // registered sample of hw_int
  logic [4:0]       exccode_q, exccode_d;
  logic [29:0]      epc_q, epc_d;  // EPC[1:0] are always zero

  logic             ack_take;
  logic             int_pending;
  logic [INT_W-1:0] ip_eff;
  logic             timer_ti;

  // Word-aligned EPC capture discards the low PC bits by design.
  logic unused_pc;
  assign unused_pc = ^pc[1:0];

  // ---------------------------------------------------------------------------
  // Optional Count/Compare timer
  // ---------------------------------------------------------------------------
`ifdef CP0_TIMER_EN
  logic [31:0] timer_count;
  logic [31:0] timer_compare;

  cp0_timer u_timer (
    .clk          (clk),
    .reset        (reset),
    .we_count_i   (we && (addr == REG_COUNT)),
    .we_compare_i (we && (addr == REG_COMPARE)),
    .din_i        (din),
    .count_o      (timer_count),
    .compare_o    (timer_compare),
    .ti_o         (timer_ti)
  );
`else
  assign timer_ti = 1'b0;
`endif

  // Only a request that is actually outstanding can be acknowledged.
  assign ack_take = exc_ack && (state_q == S_PEND);

  // The timer shares the top interrupt line with hw_int[5].
  always_comb begin
    ip_eff          = ip_q;
    ip_eff[INT_W-1] = ip_q[INT_W-1] | timer_ti;
  end

  assign int_pending = (|(im_q & ip_eff)) & ie_q & ~exl_q;

  // ---------------------------------------------------------------------------
  // SR / Cause / EPC next state. Priority, lowest first: mtc0, eret, ack.
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets its hold value before any condition, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    im_d      = im_q;
    ie_d      = ie_q;
    exl_d     = exl_q;
    epc_d     = epc_q;
    exccode_d = exccode_q;

    if (we && (addr == REG_SR)) begin
      im_d  = din[SR_IM_LSB +: INT_W];
      exl_d = din[SR_EXL_BIT];
      ie_d  = din[SR_IE_BIT];
    end
    if (we && (addr == REG_EPC)) begin
      epc_d = din[31:2];
    end

    // eret drops EXL in any state; only the FSM cares whether it was in S_HANDLER.
    if (eret) begin
      exl_d = 1'b0;
    end

    if (ack_take) begin
      epc_d     = pc[31:2];
      exl_d     = 1'b1;
      exccode_d = pend_code_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= '0;
      ie_q      <= 1'b0;
      exl_q     <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      ie_q      <= ie_d;
      exl_q     <= exl_d;
      ip_q      <= hw_int;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect FSM with registered exc_req
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      exc_req_q   <= 1'b0;
      pend_code_q <= EXC_INT;
    end else begin
      unique case (state_q)
        S_RUN: begin
          // A synchronous exception outranks an interrupt in the same cycle;
          // with EXL set it is dropped rather than queued.
          if (exc_valid && !exl_q) begin
            state_q     <= S_PEND;
            exc_req_q   <= 1'b1;
            pend_code_q <= exc_code;
          end else if (int_pending) begin
            state_q     <= S_PEND;
            exc_req_q   <= 1'b1;
            pend_code_q <= EXC_INT;
          end
        end
        S_PEND: begin
          // Latched code is held; new requests wait until after eret.
          if (exc_ack) begin
            state_q   <= S_HANDLER;
            exc_req_q <= 1'b0;
          end
        end
        S_HANDLER: begin
          if (eret) begin
            state_q <= S_RUN;
          end
        end
        default: begin
          state_q   <= S_RUN;
          exc_req_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs and mfc0 read mux
  // ---------------------------------------------------------------------------
  assign exc_req    = exc_req_q;
  assign in_handler = exl_q;
  assign epc        = {epc_q, 2'b00};

  always_comb begin
    dout = '0;
    case (addr)
      REG_SR:    dout = {16'b0, im_q, 8'b0, exl_q, ie_q};
      REG_CAUSE: dout = {1'b0, timer_ti, 14'b0, ip_eff, 3'b0, exccode_q, 2'b00};
      REG_EPC:   dout = {epc_q, 2'b00};
      REG_PRID:  dout = PRID;
`ifdef CP0_TIMER_EN
      REG_COUNT:   dout = timer_count;
      REG_COMPARE: dout = timer_compare;
`endif
      default:   dout = '0;
    endcase
  end

endmodule : cp0_unit

// File: tb/tb_cp0_unit.sv
// -----------------------------------------------------------------------------
// tb_cp0_unit
// Self-checking bench for cp0_unit. A behavioural model tracks the CP0
// registers as plain 32-bit words plus two flags (request outstanding, handler
// active) and is compared with the DUT on every falling edge. Directed
// sequences pin the model with hand-computed literals; a random phase then
// exercises the handshake, mtc0/eret/ack overlaps and resets.
// Define CP0_TIMER_EN to also exercise the Count/Compare timer.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cp0_unit;

  localparam logic [31:0] PRID_EXP = 32'h0042_0001;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [4:0]  addr;
  logic [31:0] din;
  logic        we;
  logic        eret;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic        exc_ack;
  logic        exc_req;
  logic        in_handler;
  logic [31:0] epc;
  logic [31:0] dout;

  int total = 0;
  int bad   = 0;

  cp0_unit dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .addr       (addr),
    .din        (din),
    .we         (we),
    .eret       (eret),
    .exc_valid  (exc_valid),
    .exc_code   (exc_code),
    .hw_int     (hw_int),
    .exc_ack    (exc_ack),
    .exc_req    (exc_req),
    .in_handler (in_handler),
    .epc        (epc),
    .dout       (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  bit          m_valid = 0;
  bit          m_req, m_hdl, m_ti;
  logic [31:0] m_sr, m_epc, m_count, m_compare;
  logic [4:0]  m_code, m_exccode;
  logic [5:0]  m_ip;

  function automatic logic [5:0] m_ip_eff();
    return m_ip | {m_ti, 5'b0};
  endfunction

  function automatic logic [31:0] exp_dout(input logic [4:0] a);
    case (a)
      5'd12: return m_sr;
      5'd13: return {1'b0, m_ti, 14'b0, m_ip_eff(), 10'b0} | {25'b0, m_exccode, 2'b0};
      5'd14: return m_epc;
      5'd15: return PRID_EXP;
`ifdef CP0_TIMER_EN
      5'd9:  return m_count;
      5'd11: return m_compare;
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model_step
    logic [31:0] sr_n, epc_n, count_n, compare_n;
    logic [4:0]  code_n, exccode_n;
    bit          req_n, hdl_n, ti_n, int_pend;
    if (reset) begin
      m_valid = 1; m_req = 0; m_hdl = 0; m_ti = 0;
      m_sr = 0; m_epc = 0; m_count = 0; m_compare = 0;
      m_code = 0; m_exccode = 0; m_ip = 0;
    end else if (m_valid) begin
      int_pend  = ((m_sr[15:10] & m_ip_eff()) != 6'b0) && m_sr[0] && !m_sr[1];
      sr_n = m_sr; epc_n = m_epc; code_n = m_code; exccode_n = m_exccode;
      req_n = m_req; hdl_n = m_hdl; ti_n = m_ti;
      count_n = m_count; compare_n = m_compare;

      if (we && addr == 5'd12) sr_n = din & 32'h0000_FC03;
      if (we && addr == 5'd14) epc_n = din & 32'hFFFF_FFFC;
      if (eret) sr_n[1] = 1'b0;

      if (m_req) begin
        if (exc_ack) begin
          req_n = 0; hdl_n = 1;
          epc_n = pc & 32'hFFFF_FFFC;
          sr_n[1] = 1'b1;
          exccode_n = m_code;
        end
      end else if (m_hdl) begin
        if (eret) hdl_n = 0;
      end else if (exc_valid && !m_sr[1]) begin
        req_n = 1; code_n = exc_code;
      end else if (int_pend) begin
        req_n = 1; code_n = 5'd0;
      end

`ifdef CP0_TIMER_EN
      if (m_count == m_compare && m_compare != 0) ti_n = 1;
      if (we && addr == 5'd11) begin compare_n = din; ti_n = 0; end
      count_n = (we && addr == 5'd9) ? din : m_count + 1;
`endif

      m_sr = sr_n; m_epc = epc_n; m_code = code_n; m_exccode = exccode_n;
      m_req = req_n; m_hdl = hdl_n; m_ti = ti_n;
      m_count = count_n; m_compare = compare_n;
      m_ip = hw_int;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("exc_req", {31'b0, exc_req}, {31'b0, m_req});
      check("in_handler", {31'b0, in_handler}, {31'b0, m_sr[1]});
      check("epc", epc, m_epc);
      check("dout", dout, exp_dout(addr));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we = 1; addr = a; din = d;
    step();
    we = 0;
  endtask

  task automatic peek(input logic [4:0] a, input string name, input logic [31:0] exp);
    addr = a;
    #2;
    check(name, dout, exp);
  endtask

  task automatic wait_req(input int max);
    for (int i = 0; i < max && exc_req !== 1'b1; i++) step();
  endtask

  task automatic ack(input logic [31:0] p);
    exc_ack = 1; pc = p;
    step();
    exc_ack = 0;
  endtask

  task automatic do_eret();
    eret = 1;
    step();
    eret = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset = 1; pc = 0; addr = 0; din = 0; we = 0; eret = 0;
    exc_valid = 0; exc_code = 0; hw_int = 0; exc_ack = 0;

    // 1: reset state
    repeat (3) step();
    reset = 0;
    check("rst_exc_req", {31'b0, exc_req}, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_in_handler", {31'b0, in_handler}, 32'h0);
    peek(5'd15, "rst_prid", 32'h0042_0001);
    peek(5'd12, "rst_sr", 32'h0);

    // 2: interrupt through IM[10]/IE
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    wait_req(3);
    check("t2_req", {31'b0, exc_req}, 32'h1);
    ack(32'h0000_3010);
    check("t2_epc", epc, 32'h0000_3010);
    check("t2_req_low", {31'b0, exc_req}, 32'h0);
    check("t2_in_handler", {31'b0, in_handler}, 32'h1);
    peek(5'd12, "t2_sr", 32'h0000_0403);
    peek(5'd13, "t2_cause", 32'h0000_0400);

    // 4: no request while in handler; re-request the cycle after eret
    repeat (5) step();
    check("t4_masked", {31'b0, exc_req}, 32'h0);
    do_eret();
    check("t4_exl_clr", {31'b0, in_handler}, 32'h0);
    check("t4_not_yet", {31'b0, exc_req}, 32'h0);
    step();
    check("t4_rereq", {31'b0, exc_req}, 32'h1);
    ack(32'h0000_3000);
    hw_int = 0;
    mtc0(5'd12, 32'h0);
    do_eret();

    // 3: synchronous exception is not masked by IE=0
    exc_valid = 1; exc_code = 5'd12;
    step();
    exc_valid = 0;
    check("t3_req", {31'b0, exc_req}, 32'h1);
    ack(32'h0000_3024);
    check("t3_epc", epc, 32'h0000_3024);
    peek(5'd13, "t3_cause", 32'h0000_0030);
    do_eret();

    // 5: reset while pending, after hw_int dropped
    hw_int = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    wait_req(3);
    hw_int = 0;
    step();
    check("t5_held", {31'b0, exc_req}, 32'h1);
    reset = 1;
    step();
    reset = 0;
    check("t5_req_clr", {31'b0, exc_req}, 32'h0);
    check("t5_epc_clr", epc, 32'h0);
    repeat (4) step();
    check("t5_no_rereq", {31'b0, exc_req}, 32'h0);

    // Ack with no request outstanding is ignored
    ack(32'h0000_5000);
    check("stray_ack_hdl", {31'b0, in_handler}, 32'h0);
    check("stray_ack_epc", epc, 32'h0);

    // exc_valid with EXL set (mtc0 from S_RUN) is dropped
    mtc0(5'd12, 32'h0000_0002);
    exc_valid = 1; exc_code = 5'd10;
    step();
    exc_valid = 0;
    step();
    check("exl_drop", {31'b0, exc_req}, 32'h0);
    mtc0(5'd12, 32'h0);

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      reset     = ($urandom_range(0, 249) == 0);
      we        = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 7))
        0: addr = 5'd9;
        1: addr = 5'd11;
        2: addr = 5'd12;
        3: addr = 5'd13;
        4: addr = 5'd14;
        5: addr = 5'd15;
        default: addr = 5'($urandom);
      endcase
      din       = $urandom;
      eret      = ($urandom_range(0, 7) == 0);
      exc_valid = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: exc_code = 5'd4;
        1: exc_code = 5'd5;
        2: exc_code = 5'd10;
        default: exc_code = 5'd12;
      endcase
      exc_ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) hw_int = 6'($urandom);
      pc        = $urandom;
      step();
    end
    reset = 1; we = 0; eret = 0; exc_valid = 0; exc_ack = 0; hw_int = 0;
    repeat (2) step();
    reset = 0;

`ifdef CP0_TIMER_EN
    // 6: timer interrupt through IM[15]
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd0);
    wait_req(40);
    check("t6_timer_req", {31'b0, exc_req}, 32'h1);
    ack(32'h0000_4000);
    mtc0(5'd11, 32'd0);
    peek(5'd13, "t6_ti_clr", 32'h0);
    do_eret();
    repeat (40) step();
    check("t6_no_req", {31'b0, exc_req}, 32'h0);
`endif

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cp0_unit
